// File: rtl/sst_eng_pkg.sv
// Shared definitions for the save-state sequencer.
// Holds the sequencer state encoding, the sticky error codes reported on
// the err port, and the default address of the mapper index register.
package sst_eng_pkg;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_RD_SET  = 4'd1,
    ST_RD_WAIT = 4'd2,
    ST_RD_PUSH = 4'd3,
    ST_WR_GET  = 4'd4,
    ST_WR_ARM  = 4'd5,
    ST_WR_NEXT = 4'd6,
    ST_FIN     = 4'd7,
    ST_FAIL    = 4'd8
  } sst_state_e;

  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_IDX  = 2'd1;
  localparam logic [1:0] ERR_TMO  = 2'd2;

  localparam int IDX_ADDR_DEF = 127;

endpackage

// File: rtl/sst_engine_m2_edge_sync.sv
// M2 synchronizer and falling-edge detector.
// Brings the raw cartridge M2 into the clk domain through two flops and
// emits a one-clk pulse on each synchronized 1 -> 0 transition.
// Ports:
//   clk     in  system clock
//   rst_n   in  asynchronous active-low reset
//   m2      in  raw M2, asynchronous to clk
//   m2_fall out one-clk pulse per synchronized falling edge (registered)
module m2_edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic m2,
  output logic m2_fall
);

  logic meta_r;
  logic sync_r;
  logic fall_r;

  // Two-flop synchronizer; the edge flag compares the synced value with the
  // value about to be shifted in, so the pulse comes out of a flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_r <= 1'b0;
      sync_r <= 1'b0;
      fall_r <= 1'b0;
    end else begin
      meta_r <= m2;
      sync_r <= meta_r;
      fall_r <= sync_r & ~meta_r;
    end
  end

  assign m2_fall = fall_r;

endmodule

// File: rtl/sst_engine.sv
// Save-state sequencer between the host byte stream and the mapper
// save-state port.
// Dump: walks addresses 0..REG_CNT-1, waits RD_WAIT clks for sst_di to
// settle, and streams each byte out on out_data/out_valid/out_ready.
// Load: takes bytes on in_data/in_valid/in_ready and writes them with
// sst_we_reg held across at least one full M2 falling edge. The index
// address is never written; its incoming byte must match the mapper.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   m2                         raw cartridge M2
//   cmd_dump, cmd_load         one-clk start pulses (dump wins if both)
//   busy, done, err            status; err is sticky until the next command
//   out_data/out_valid/out_ready   dump byte stream
//   in_data/in_valid/in_ready      load byte stream
//   sst_act, sst_addr, sst_we_reg, sst_dato, sst_di   mapper save-state port
module sst_engine
  import sst_eng_pkg::*;
#(
  parameter int REG_CNT  = 128,
  parameter int IDX_ADDR = IDX_ADDR_DEF,
  parameter int RD_WAIT  = 2,
  parameter int M2_TMO   = 4096
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       m2,
  input  logic       cmd_dump,
  input  logic       cmd_load,
  output logic       busy,
  output logic       done,
  output logic [1:0] err,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       sst_act,
  output logic [7:0] sst_addr,
  output logic       sst_we_reg,
  output logic [7:0] sst_dato,
  input  logic [7:0] sst_di
);

  localparam int         TMO_W     = $clog2(M2_TMO + 1);
  localparam logic [7:0] ADDR_LAST = 8'(REG_CNT - 1);
  localparam logic [7:0] ADDR_IDX  = 8'(IDX_ADDR);
  localparam logic [7:0] WAIT_CNT  = 8'(RD_WAIT);
  localparam logic [7:0] WAIT_LAST = 8'(RD_WAIT - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(M2_TMO - 1);

  sst_state_e       state_r, state_nxt;
  logic [7:0]       addr_r, addr_nxt;
  logic [7:0]       wcnt_r, wcnt_nxt;
  logic [TMO_W-1:0] tmo_r, tmo_nxt;
  logic             seen_r, seen_nxt;
  logic [7:0]       data_r, data_nxt;
  logic [7:0]       dato_r, dato_nxt;
  logic [1:0]       err_r, err_nxt;
  logic             busy_r, busy_nxt;
  logic             done_r, done_nxt;
  logic             valid_r, valid_nxt;
  logic             ready_r, ready_nxt;
  logic             we_r, we_nxt;
  logic             m2_fall_s;

  m2_edge_sync u_m2_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .m2      (m2),
    .m2_fall (m2_fall_s)
  );

  // Next-state and datapath decisions for the sequencer.
  always_comb begin
    state_nxt = state_r;
    addr_nxt  = addr_r;
    wcnt_nxt  = wcnt_r;
    tmo_nxt   = tmo_r;
    seen_nxt  = seen_r;
    data_nxt  = data_r;
    dato_nxt  = dato_r;
    err_nxt   = err_r;
    case (state_r)
      ST_IDLE: begin
        if (cmd_dump) begin
          state_nxt = ST_RD_SET;
          addr_nxt  = 8'd0;
          err_nxt   = ERR_NONE;
        end else if (cmd_load) begin
          state_nxt = ST_WR_GET;
          addr_nxt  = 8'd0;
          wcnt_nxt  = 8'd0;
          err_nxt   = ERR_NONE;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_RD_SET: begin
        wcnt_nxt  = 8'd0;
        state_nxt = ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        if (wcnt_r >= WAIT_LAST) begin
          data_nxt  = sst_di;
          state_nxt = ST_RD_PUSH;
        end else begin
          wcnt_nxt = wcnt_r + 8'd1;
        end
      end
      ST_RD_PUSH: begin
        if (valid_r && out_ready) begin
          if (addr_r == ADDR_LAST) begin
            state_nxt = ST_FIN;
          end else begin
            addr_nxt  = addr_r + 8'd1;
            state_nxt = ST_RD_SET;
          end
        end else begin
          state_nxt = ST_RD_PUSH;
        end
      end
      ST_WR_GET: begin
        // Hold off the byte until sst_di has settled for the new address,
        // so the index compare sees valid mapper data.
        if (wcnt_r < WAIT_CNT) begin
          wcnt_nxt = wcnt_r + 8'd1;
        end else if (ready_r && in_valid) begin
          if (addr_r == ADDR_IDX) begin
            if (in_data != sst_di) begin
              err_nxt   = ERR_IDX;
              state_nxt = ST_FAIL;
            end else begin
              state_nxt = ST_WR_NEXT;
            end
          end else begin
            dato_nxt  = in_data;
            tmo_nxt   = {TMO_W{1'b0}};
            seen_nxt  = 1'b0;
            state_nxt = ST_WR_ARM;
          end
        end else begin
          state_nxt = ST_WR_GET;
        end
      end
      ST_WR_ARM: begin
        // The first fall may predate the strobe; the second one is
        // guaranteed to have happened entirely while it was high.
        if (m2_fall_s) begin
          tmo_nxt = {TMO_W{1'b0}};
          if (seen_r) begin
            state_nxt = ST_WR_NEXT;
          end else begin
            seen_nxt = 1'b1;
          end
        end else if (tmo_r == TMO_LAST) begin
          err_nxt   = ERR_TMO;
          state_nxt = ST_FAIL;
        end else begin
          tmo_nxt = tmo_r + TMO_W'(1);
        end
      end
      ST_WR_NEXT: begin
        wcnt_nxt = 8'd0;
        if (addr_r == ADDR_LAST) begin
          state_nxt = ST_FIN;
        end else begin
          addr_nxt  = addr_r + 8'd1;
          state_nxt = ST_WR_GET;
        end
      end
      ST_FIN:  state_nxt = ST_IDLE;
      ST_FAIL: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Output decode from the next state, so every port comes from a flop.
  always_comb begin
    busy_nxt  = 1'b0;
    done_nxt  = 1'b0;
    valid_nxt = 1'b0;
    ready_nxt = 1'b0;
    we_nxt    = 1'b0;
    case (state_nxt)
      ST_IDLE, ST_FAIL: busy_nxt = 1'b0;
      ST_FIN:           done_nxt = 1'b1;
      ST_RD_PUSH: begin
        busy_nxt  = 1'b1;
        valid_nxt = 1'b1;
      end
      ST_WR_GET: begin
        busy_nxt  = 1'b1;
        ready_nxt = (wcnt_nxt == WAIT_CNT);
      end
      ST_WR_ARM: begin
        busy_nxt = 1'b1;
        we_nxt   = 1'b1;
      end
      ST_RD_SET, ST_RD_WAIT, ST_WR_NEXT: busy_nxt = 1'b1;
      default: busy_nxt = 1'b0;
    endcase
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      addr_r  <= 8'd0;
      wcnt_r  <= 8'd0;
      tmo_r   <= {TMO_W{1'b0}};
      seen_r  <= 1'b0;
      data_r  <= 8'd0;
      dato_r  <= 8'd0;
      err_r   <= ERR_NONE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      valid_r <= 1'b0;
      ready_r <= 1'b0;
      we_r    <= 1'b0;
    end else begin
      state_r <= state_nxt;
      addr_r  <= addr_nxt;
      wcnt_r  <= wcnt_nxt;
      tmo_r   <= tmo_nxt;
      seen_r  <= seen_nxt;
      data_r  <= data_nxt;
      dato_r  <= dato_nxt;
      err_r   <= err_nxt;
      busy_r  <= busy_nxt;
      done_r  <= done_nxt;
      valid_r <= valid_nxt;
      ready_r <= ready_nxt;
      we_r    <= we_nxt;
    end
  end

  assign busy       = busy_r;
  assign sst_act    = busy_r;
  assign done       = done_r;
  assign err        = err_r;
  assign out_data   = data_r;
  assign out_valid  = valid_r;
  assign in_ready   = ready_r;
  assign sst_addr   = addr_r;
  assign sst_we_reg = we_r;
  assign sst_dato   = dato_r;

endmodule

// File: doc/sst_engine.md
Name: sst_engine

Overview:
- Save-state sequencer feeding the mapper save-state port: drives sst_act/sst_addr/sst_we_reg/sst_dato and captures sst_di.
- Dump: walks mapper register addresses 0..REG_CNT-1 and streams each byte out.
- Load: streams bytes in and writes them back, aligned to M2 falling edges, which is when the mapper samples its save-state writes.
- Sits between the host byte-stream channel and the active mapper module.

Parameters:
- REG_CNT, 128, number of save-state addresses walked (0..REG_CNT-1); must be 2..256.
- IDX_ADDR, 127, address holding the mapper index (read-only on load; used for the compatibility check).
- RD_WAIT, 2, clk cycles between sst_addr change and sst_di capture.
- M2_TMO, 4096, clk cycles allowed between M2 falling edges before timeout.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- m2  in  1  raw cartridge M2, asynchronous to clk
- cmd_dump  in  1  one-clk start-dump pulse
- cmd_load  in  1  one-clk start-load pulse
- busy  out  1  operation in progress
- done  out  1  one-clk pulse on successful completion
- err  out  2  sticky error code: 0 none, 1 index mismatch, 2 M2 timeout; cleared on next command
- out_data  out  8  dump byte
- out_valid  out  1  dump byte valid
- out_ready  in  1  host accepts dump byte
- in_data  in  8  load byte
- in_valid  in  1  load byte valid
- in_ready  out  1  engine accepts load byte
- sst_act  out  1  save-state active (freezes mapper CPU writes)
- sst_addr  out  8  save-state register address
- sst_we_reg  out  1  register write strobe
- sst_dato  out  8  write data to mapper
- sst_di  in  8  read data from mapper

Behaviour:
- Reset values:
  - all outputs 0, sst_addr 0, state IDLE.
  - Reset mid-operation aborts immediately: sst_act drops and no done is issued.
- M2 handling:
  - m2 passes through a 2-flop synchronizer.
  - m2_fall = synced 1 -> 0 transition, one clk wide.
- States: IDLE, RD_SET, RD_WAIT, RD_PUSH, WR_GET, WR_ARM, WR_NEXT, FIN, FAIL.
- IDLE:
  - cmd_dump -> RD_SET; cmd_load -> WR_GET.
  - Both asserted in the same cycle: dump wins.
  - Commands are ignored while busy.
  - Any accepted command clears err, sets sst_addr=0, and asserts sst_act and busy.
- RD_SET: sst_we_reg=0 -> RD_WAIT.
- RD_WAIT: count RD_WAIT clks, then latch sst_di into out_data -> RD_PUSH.
- RD_PUSH:
  - Hold out_valid=1 with out_data stable until out_ready.
  - On handshake: if sst_addr==REG_CNT-1 -> FIN; else sst_addr+1 -> RD_SET.
- WR_GET:
  - in_ready=1; on in_valid&in_ready capture in_data.
  - If sst_addr==IDX_ADDR: compare the byte with sst_di (sst_di is sampled after the RD_WAIT settle, counted from the address change).
    - Mismatch: err=1 -> FAIL.
    - Match: -> WR_NEXT, with no write.
  - Otherwise: sst_dato=byte -> WR_ARM.
- WR_ARM:
  - Assert sst_we_reg with sst_addr/sst_dato stable.
  - Stay until two m2_fall events have been seen; the second guarantees one full M2 falling edge occurred with the strobe stable.
  - Then deassert -> WR_NEXT.
- WR_NEXT: if sst_addr==REG_CNT-1 -> FIN; else sst_addr+1 -> WR_GET.
- Timeout:
  - In WR_ARM, a counter resets on each m2_fall.
  - Reaching M2_TMO sets err=2 -> FAIL.
- FIN: pulse done, drop sst_act/busy -> IDLE.
- FAIL: drop sst_act/sst_we_reg/busy with no done pulse; discard any pending stream byte -> IDLE.
- Invariants:
  - sst_addr never exceeds REG_CNT-1; no wrap.
  - sst_we_reg is only ever high in WR_ARM.
  - out_valid and in_ready are never high together.

Decomposition:
- Package sst_eng_pkg holds:
  - the state enum;
  - error codes ERR_NONE=0, ERR_IDX=1, ERR_TMO=2;
  - default IDX_ADDR.
- One sub-module, m2_edge_sync: 2-flop synchronizer plus falling-edge detector, with clk/rst_n/m2 in and m2_fall out.

Test Plan:
- Dump, mapper model with reg0=8'h0B and addr127=8'h94, out_ready tied 1 -> 128 bytes out, byte0=0x0B, byte127=0x94, one done pulse, sst_act low afterwards.
- Dump with out_ready toggling every 3 clks -> identical byte sequence, out_data stable while out_valid&!out_ready.
- Load of 128 bytes, byte0=0x05, byte127 matching index, M2 period 12 clks -> model reg0=0x05, each write spans ≥1 M2 fall, address 127 never written, done asserted.
- Load with byte127=0x00 vs index 0x94 -> err=1, no done, sst_act drops, writes to 0..126 already applied.
- Load with m2 held high -> err=2 after 4096 clks in the first WR_ARM, sst_we_reg low afterwards.
- rst_n asserted mid-load at address 40 -> all outputs 0 asynchronously; a new cmd_dump afterwards starts at address 0 with err=0.
